// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch initiator with IF/ID pipeline register.
//
// Drives the instruction ROM (chip enable + byte address = PC) and captures
// the combinational ROM word into the IF/ID register. Handles stall, branch
// and flush redirects, raises a sticky fault on misaligned or out-of-range
// fetch addresses, and counts instructions delivered to decode.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   stall_i          hold PC, IF/ID and counter
//   flush_i          redirect to new_pc_i (highest priority)
//   new_pc_i         flush target
//   branch_flag_i    taken branch from decode
//   branch_target_i  branch target
//   rom_ce_o         ROM chip enable
//   rom_addr_o       ROM byte address (the PC register)
//   rom_inst_i       ROM data word (combinational)
//   if_pc_o          IF/ID: PC of captured instruction
//   if_inst_o        IF/ID: captured instruction
//   if_valid_o       IF/ID contents valid
//   fetch_fault_o    sticky fetch fault flag
//   fault_pc_o       PC that caused the fault
//   fetch_cnt_o      delivered-instruction count (wraps)
module inst_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned ROM_DEPTH_LOG2 = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        fetch_fault_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FAULT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] if_pc, if_pc_nxt;
    logic [31:0] if_inst, if_inst_nxt;
    logic        if_valid, if_valid_nxt;
    logic        fault, fault_nxt;
    logic [31:0] fault_pc, fault_pc_nxt;
    logic [31:0] cnt, cnt_nxt;

    logic [29:0] pc_word;
    logic        pc_bad;

    // Out of range when any word-index bit at or above ROM_DEPTH_LOG2 is set.
    assign pc_word = pc[31:2];
    assign pc_bad  = (pc[1:0] != 2'b00) || ((pc_word >> ROM_DEPTH_LOG2) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            if_pc    <= '0;
            if_inst  <= '0;
            if_valid <= 1'b0;
            fault    <= 1'b0;
            fault_pc <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            if_pc    <= if_pc_nxt;
            if_inst  <= if_inst_nxt;
            if_valid <= if_valid_nxt;
            fault    <= fault_nxt;
            fault_pc <= fault_pc_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        if_pc_nxt    = if_pc;
        if_inst_nxt  = if_inst;
        if_valid_nxt = if_valid;
        fault_nxt    = fault;
        fault_pc_nxt = fault_pc;
        cnt_nxt      = cnt;

        unique case (state)
            S_BOOT: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (flush_i) begin
                    pc_nxt       = new_pc_i;
                    if_pc_nxt    = '0;
                    if_inst_nxt  = '0;
                    if_valid_nxt = 1'b0;
                end else if (pc_bad && !stall_i) begin
                    state_nxt    = S_FAULT;
                    fault_nxt    = 1'b1;
                    fault_pc_nxt = pc;
                    if_valid_nxt = 1'b0;
                end else if (!stall_i) begin
                    // Capture the word at pc; a branch still keeps this delay slot.
                    if_inst_nxt  = rom_inst_i;
                    if_pc_nxt    = pc;
                    if_valid_nxt = 1'b1;
                    cnt_nxt      = cnt + 32'd1;
                    pc_nxt       = branch_flag_i ? branch_target_i : pc + 32'd4;
                end
            end
            S_FAULT: begin
                if (flush_i) begin
                    state_nxt = S_RUN;
                    pc_nxt    = new_pc_i;
                    fault_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    assign rom_ce_o      = (state == S_RUN);
    assign rom_addr_o    = pc;
    assign if_pc_o       = if_pc;
    assign if_inst_o     = if_inst;
    assign if_valid_o    = if_valid;
    assign fetch_fault_o = fault;
    assign fault_pc_o    = fault_pc;
    assign fetch_cnt_o   = cnt;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a behavioural reference
// model checked every falling edge, plus hand-computed literal expectations.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned ROM_LOG2 = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, branch_flag_i;
    logic [31:0] new_pc_i, branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o, rom_inst_i;
    logic [31:0] if_pc_o, if_inst_o, fault_pc_o, fetch_cnt_o;
    logic        if_valid_o, fetch_fault_o;

    int n_chk  = 0;
    int n_fail = 0;

    inst_fetch #(
        .RESET_PC       (RESET_PC),
        .ROM_DEPTH_LOG2 (ROM_LOG2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_valid_o      (if_valid_o),
        .fetch_fault_o   (fetch_fault_o),
        .fault_pc_o      (fault_pc_o),
        .fetch_cnt_o     (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    // ROM contents: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr / 4);
    endfunction

    assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o) : 32'h0;

    function automatic bit bad_addr(input logic [31:0] addr);
        longint unsigned word;
        word = longint'(addr) / 4;
        return ((addr % 4) != 0) || (word >= (64'd1 << ROM_LOG2));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: fetching / halted / booting behaviour from the rules.
    logic [31:0] m_pc, m_if_pc, m_if_inst, m_fault_pc, m_cnt;
    logic        m_valid, m_fault, m_booting, m_halted;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc <= RESET_PC; m_if_pc <= 0; m_if_inst <= 0; m_valid <= 0;
            m_fault <= 0; m_fault_pc <= 0; m_cnt <= 0;
            m_booting <= 1; m_halted <= 0;
        end else if (m_booting) begin
            m_booting <= 0;
        end else if (m_halted) begin
            if (flush_i) begin
                m_pc <= new_pc_i; m_fault <= 0; m_halted <= 0;
            end
        end else if (flush_i) begin
            m_pc <= new_pc_i; m_valid <= 0; m_if_inst <= 0; m_if_pc <= 0;
        end else if (stall_i) begin
            // everything held
        end else if (bad_addr(m_pc)) begin
            m_halted <= 1; m_fault <= 1; m_fault_pc <= m_pc; m_valid <= 0;
        end else begin
            m_if_inst <= rom_word(m_pc);
            m_if_pc   <= m_pc;
            m_valid   <= 1;
            m_cnt     <= m_cnt + 1;
            m_pc      <= branch_flag_i ? branch_target_i : m_pc + 4;
        end
    end

    always @(negedge clk) begin
        chk("rom_ce",     {31'b0, rom_ce_o},      {31'b0, !m_booting && !m_halted});
        chk("rom_addr",   rom_addr_o,             m_pc);
        chk("if_pc",      if_pc_o,                m_if_pc);
        chk("if_inst",    if_inst_o,              m_if_inst);
        chk("if_valid",   {31'b0, if_valid_o},    {31'b0, m_valid});
        chk("fault",      {31'b0, fetch_fault_o}, {31'b0, m_fault});
        chk("fault_pc",   fault_pc_o,             m_fault_pc);
        chk("fetch_cnt",  fetch_cnt_o,            m_cnt);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        stall_i = 0; flush_i = 0; branch_flag_i = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 0; idle(); new_pc_i = 0; branch_target_i = 0;
        #2;
        chk("rst_ce",   {31'b0, rom_ce_o}, 32'h0);
        chk("rst_addr", rom_addr_o,        32'h0);
        chk("rst_cnt",  fetch_cnt_o,       32'h0);
        @(negedge clk); rst = 1;

        step(); chk("e1_ce", {31'b0, rom_ce_o}, 32'h1); chk("e1_valid", {31'b0, if_valid_o}, 32'h0);
        step(); chk("e2_inst", if_inst_o, 32'h1000_0000); chk("e2_pc", if_pc_o, 32'h0);
        chk("e2_valid", {31'b0, if_valid_o}, 32'h1);
        step(); step(); chk("e4_pc", if_pc_o, 32'h8); chk("e4_cnt", fetch_cnt_o, 32'd3);
        step(); chk("pre_stall_addr", rom_addr_o, 32'h10);

        stall_i = 1;
        repeat (3) begin
            step();
            chk("stall_addr", rom_addr_o, 32'h10); chk("stall_ifpc", if_pc_o, 32'h0C);
            chk("stall_cnt", fetch_cnt_o, 32'd4);
        end
        stall_i = 0;
        step(); chk("unstall_ifpc", if_pc_o, 32'h10); chk("unstall_cnt", fetch_cnt_o, 32'd5);

        branch_flag_i = 1; branch_target_i = 32'h40;
        step(); chk("br_slot_pc", if_pc_o, 32'h14); chk("br_addr", rom_addr_o, 32'h40);
        idle();
        step(); chk("br_tgt_pc", if_pc_o, 32'h40); chk("br_cnt", fetch_cnt_o, 32'd7);

        flush_i = 1; new_pc_i = 32'h20; stall_i = 1; branch_flag_i = 1; branch_target_i = 32'h80;
        step(); chk("fl_addr", rom_addr_o, 32'h20); chk("fl_valid", {31'b0, if_valid_o}, 32'h0);
        chk("fl_cnt", fetch_cnt_o, 32'd7);
        idle();
        step(); chk("fl_next_pc", if_pc_o, 32'h20);

        branch_flag_i = 1; branch_target_i = 32'h102;
        step(); chk("mis_addr", rom_addr_o, 32'h102);
        idle();
        step(); chk("mis_fault", {31'b0, fetch_fault_o}, 32'h1); chk("mis_fpc", fault_pc_o, 32'h102);
        chk("mis_ce", {31'b0, rom_ce_o}, 32'h0); chk("mis_valid", {31'b0, if_valid_o}, 32'h0);
        stall_i = 1; branch_flag_i = 1; branch_target_i = 32'h200;
        repeat (2) begin
            step(); chk("hold_addr", rom_addr_o, 32'h102); chk("hold_cnt", fetch_cnt_o, 32'd9);
        end
        idle(); flush_i = 1; new_pc_i = 32'h0;
        step(); chk("clr_fault", {31'b0, fetch_fault_o}, 32'h0); chk("clr_addr", rom_addr_o, 32'h0);
        idle();
        step(); chk("resume_inst", if_inst_o, 32'h1000_0000); chk("resume_cnt", fetch_cnt_o, 32'd10);

        flush_i = 1; new_pc_i = 32'h28;
        step(); idle();
        step(); step(); chk("mid_addr", rom_addr_o, 32'h30); chk("mid_cnt", fetch_cnt_o, 32'd12);
        #2 rst = 0;
        #1;
        chk("arst_addr", rom_addr_o, 32'h0); chk("arst_ce", {31'b0, rom_ce_o}, 32'h0);
        chk("arst_cnt", fetch_cnt_o, 32'h0); chk("arst_fpc", fault_pc_o, 32'h0);
        @(negedge clk); rst = 1;
        step(); chk("boot_valid", {31'b0, if_valid_o}, 32'h0); chk("boot_ce", {31'b0, rom_ce_o}, 32'h1);
        step(); chk("boot_cnt", fetch_cnt_o, 32'd1);

        // Last in-range word, then first out-of-range word.
        flush_i = 1; new_pc_i = 32'h0007_FFFC;
        step(); idle();
        step(); chk("top_inst", if_inst_o, 32'h1001_FFFF); chk("top_addr", rom_addr_o, 32'h0008_0000);
        flush_i = 1; new_pc_i = 32'h100;
        step(); chk("fl_over_fault", {31'b0, fetch_fault_o}, 32'h0); chk("fl_over_addr", rom_addr_o, 32'h100);
        new_pc_i = 32'h0008_0000;
        step(); idle();
        step(); chk("oor_fault", {31'b0, fetch_fault_o}, 32'h1); chk("oor_fpc", fault_pc_o, 32'h0008_0000);
        flush_i = 1; new_pc_i = 32'h0;
        step(); idle();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch initiator that drives the instruction ROM's chip-enable/address interface and consumes its combinational instruction word. It holds the PC and applies stall, branch and flush redirects. It also contains the IF/ID pipeline register feeding decode. It detects misaligned or out-of-range fetch addresses, raises a fetch fault, and counts delivered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
ROM_DEPTH_LOG2, 17, log2 of ROM word count; a PC whose word index (pc[31:2]) is >= 2^ROM_DEPTH_LOG2 is out of range.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
stall_i  input  1  hold PC and IF/ID contents
flush_i  input  1  exception/eret redirect; highest priority
new_pc_i  input  32  redirect target when flush_i=1
branch_flag_i  input  1  taken branch resolved in decode
branch_target_i  input  32  branch target
rom_ce_o  output  1  ROM chip enable, 1 = enabled
rom_addr_o  output  32  byte address to ROM (= pc register)
rom_inst_i  input  32  ROM data, combinational from rom_ce_o/rom_addr_o in same cycle; zero when ce=0
if_pc_o  output  32  IF/ID: PC of captured instruction
if_inst_o  output  32  IF/ID: captured instruction
if_valid_o  output  1  IF/ID contents valid
fetch_fault_o  output  1  sticky fault flag
fault_pc_o  output  32  offending PC
fetch_cnt_o  output  32  instructions delivered to IF/ID, wraps mod 2^32

Behaviour:
- Reset (rst=0, async, any time including mid-operation): state=S_BOOT, pc=RESET_PC, rom_ce_o=0, rom_addr_o=RESET_PC. if_pc_o, if_inst_o, if_valid_o, fetch_fault_o, fault_pc_o and fetch_cnt_o are all 0.
- rom_addr_o is always the pc register. rom_ce_o=1 only in S_RUN; it is 0 in S_BOOT and S_FAULT.
- States:
  - S_BOOT: one idle cycle after reset release, next edge -> S_RUN with no other state change.
  - S_RUN: normal fetch.
  - S_FAULT: fetch halted.
- Fault check (S_RUN, combinational on pc): fault when pc[1:0]!=0, or pc[31:2] >= 2^ROM_DEPTH_LOG2.
- On a rising edge in S_RUN, priority is:
  1. flush_i: pc<=new_pc_i; if_valid_o<=0; if_inst_o<=0; if_pc_o<=0; stay S_RUN. This also overrides a pending fault.
  2. fault (with stall_i=0): ->S_FAULT; fetch_fault_o<=1; fault_pc_o<=pc; if_valid_o<=0; pc held.
  3. stall_i: pc, IF/ID, counter all held. The fault check is deferred until the stall drops.
  4. branch_flag_i: if_inst_o<=rom_inst_i; if_pc_o<=pc; if_valid_o<=1. The delay-slot instruction is kept. pc<=branch_target_i.
  5. otherwise: capture as in item 4; pc<=pc+4 (mod 2^32).
- fetch_cnt_o increments by 1 on every edge where if_valid_o is loaded with 1.
- S_FAULT: every output is held. Only flush_i leaves it: pc<=new_pc_i, fetch_fault_o<=0, ->S_RUN. stall_i and branch_flag_i are ignored.
- Latency: an instruction at PC X appears on if_inst_o one edge after rom_addr_o=X with ce=1 and no stall. First valid instruction after reset release is at the 2nd rising edge.
- Simultaneous flush_i and stall_i: flush wins. Simultaneous branch_flag_i and stall_i: stall wins, and the branch must be re-presented by the producer. The block does not remember it.

Test Plan:
- Reset release, RESET_PC=0, ROM word k = 32'h1000_0000+k, no stall → edge1: rom_ce_o=1; edge2: if_inst_o=32'h1000_0000, if_pc_o=0, if_valid_o=1; edge4: if_pc_o=8, fetch_cnt_o=3.
- Stall asserted 3 cycles while pc=0x10 → rom_addr_o stays 0x10, if_pc_o stays 0x0C, fetch_cnt_o frozen; after release, the next edge gives if_pc_o=0x10.
- branch_flag_i=1, branch_target_i=0x40 at pc=0x14 → if_pc_o=0x14 (delay slot captured), rom_addr_o=0x40; the next capture has if_pc_o=0x40.
- flush_i with new_pc_i=0x20 together with stall_i and branch_flag_i → rom_addr_o=0x20, if_valid_o=0, fetch_cnt_o unchanged.
- branch_target_i=0x102 (misaligned) → next edge: fetch_fault_o=1, fault_pc_o=0x102, rom_ce_o=0, if_valid_o=0. Outputs stay held under stall/branch until flush_i with new_pc_i=0x0 clears the fault and resumes fetch at 0.
- Assert rst mid-run (pc=0x30, fetch_cnt_o=12) between edges → all outputs go to reset values immediately (pc=0, rom_ce_o=0, fetch_cnt_o=0). One S_BOOT cycle follows release.
